// File: rtl/fnd_pkg.sv
// Shared constants for the seven-segment scan reader: select encodings,
// active-low segment fonts (g..a) and the frame-collection state type.
package fnd_pkg;

  localparam logic [3:0] SEL_POS0 = 4'b1110;
  localparam logic [3:0] SEL_POS1 = 4'b1101;
  localparam logic [3:0] SEL_POS2 = 4'b1011;
  localparam logic [3:0] SEL_POS3 = 4'b0111;

  localparam logic [6:0] FONT_0 = 7'b1000000;
  localparam logic [6:0] FONT_1 = 7'b1111001;
  localparam logic [6:0] FONT_2 = 7'b0100100;
  localparam logic [6:0] FONT_3 = 7'b0110000;
  localparam logic [6:0] FONT_4 = 7'b0011001;
  localparam logic [6:0] FONT_5 = 7'b0010010;
  localparam logic [6:0] FONT_6 = 7'b0000010;
  localparam logic [6:0] FONT_7 = 7'b1111000;
  localparam logic [6:0] FONT_8 = 7'b0000000;
  localparam logic [6:0] FONT_9 = 7'b0010000;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } fndState_t;

endpackage

// File: rtl/fnd_font_decoder.sv
// Combinational glyph decoder: 7-bit active-low font -> {bad, BCD}.
// Unknown glyphs decode to 4'hF with the bad flag set.
module fnd_font_decoder
  import fnd_pkg::*;
(
  input  logic [6:0] i_font,
  output logic [4:0] o_decoded
);

  // Map each known glyph to its digit value
  always_comb begin
    o_decoded = {1'b1, 4'hF};
    case (i_font)
      FONT_0:  o_decoded = {1'b0, 4'd0};
      FONT_1:  o_decoded = {1'b0, 4'd1};
      FONT_2:  o_decoded = {1'b0, 4'd2};
      FONT_3:  o_decoded = {1'b0, 4'd3};
      FONT_4:  o_decoded = {1'b0, 4'd4};
      FONT_5:  o_decoded = {1'b0, 4'd5};
      FONT_6:  o_decoded = {1'b0, 4'd6};
      FONT_7:  o_decoded = {1'b0, 4'd7};
      FONT_8:  o_decoded = {1'b0, 4'd8};
      FONT_9:  o_decoded = {1'b0, 4'd9};
      default: o_decoded = {1'b1, 4'hF};
    endcase
  end

endmodule

// File: rtl/fnd_scan_reader.sv
// Reads a multiplexed 4-digit seven-segment scan back into BCD: each digit is
// captured once after its select/font has settled, and frames are assembled 0..3.
module fnd_scan_reader
  import fnd_pkg::*;
#(
  parameter int P_SETTLE_CYCLES  = 4,
  parameter int P_TIMEOUT_CYCLES = 200000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [3:0]  i_digitSelect,
  input  logic [7:0]  i_fndFont,
  output logic [15:0] o_value,
  output logic [3:0]  o_dp,
  output logic        o_valid,
  output logic        o_error,
  output logic [1:0]  o_digitPosition
);

  localparam int              TO_W         = $clog2(P_TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      SETTLE_MAX   = 8'(P_SETTLE_CYCLES);
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(P_TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TIMEOUT_ONE  = TO_W'(1);

  logic [3:0]      selReg_r;
  logic [3:0]      selPrev_r;
  logic [7:0]      fontReg_r;
  logic [7:0]      fontPrev_r;
  logic [7:0]      settleCnt_r;
  logic            captured_r;
  logic [TO_W-1:0] timeoutCnt_r;
  fndState_t       state_r;
  logic [1:0]      expected_r;
  logic [15:0]     shadowValue_r;
  logic [3:0]      shadowDp_r;
  logic            badFrame_r;

  logic            digitValid_s;
  logic [1:0]      digitPos_s;
  logic            stable_s;
  logic            capture_s;
  logic [4:0]      decoded_s;
  logic [3:0]      nibble_s;
  logic            glyphBad_s;
  logic            dp_s;

  // Translate the registered one-cold select into a digit position
  always_comb begin
    digitValid_s = 1'b1;
    digitPos_s   = 2'd0;
    case (selReg_r)
      SEL_POS0: digitPos_s = 2'd0;
      SEL_POS1: digitPos_s = 2'd1;
      SEL_POS2: digitPos_s = 2'd2;
      SEL_POS3: digitPos_s = 2'd3;
      default: begin
        digitValid_s = 1'b0;
        digitPos_s   = 2'd0;
      end
    endcase
  end

  assign stable_s   = (selReg_r == selPrev_r) && (fontReg_r == fontPrev_r);
  // captured_r blocks a second capture while the same glyph keeps dwelling
  assign capture_s  = digitValid_s && stable_s && (settleCnt_r == SETTLE_MAX) && !captured_r;
  assign glyphBad_s = decoded_s[4];
  assign nibble_s   = decoded_s[3:0];
  assign dp_s       = ~fontReg_r[7];

  fnd_font_decoder uFontDecoder (
    .i_font    (fontReg_r[6:0]),
    .o_decoded (decoded_s)
  );

  // Input registers and settle counter
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      selReg_r    <= 4'b1111;
      selPrev_r   <= 4'b1111;
      fontReg_r   <= 8'h00;
      fontPrev_r  <= 8'h00;
      settleCnt_r <= 8'd0;
      captured_r  <= 1'b0;
    end else begin
      selReg_r   <= i_digitSelect;
      fontReg_r  <= i_fndFont;
      selPrev_r  <= selReg_r;
      fontPrev_r <= fontReg_r;
      if (!stable_s || !digitValid_s) begin
        settleCnt_r <= 8'd0;
        captured_r  <= 1'b0;
      end else begin
        if (settleCnt_r != SETTLE_MAX) begin
          settleCnt_r <= settleCnt_r + 8'd1;
        end
        if (capture_s) begin
          captured_r <= 1'b1;
        end
      end
    end
  end

  // Frame-collection FSM with registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r         <= ST_IDLE;
      expected_r      <= 2'd0;
      shadowValue_r   <= 16'h0000;
      shadowDp_r      <= 4'h0;
      badFrame_r      <= 1'b0;
      timeoutCnt_r    <= '0;
      o_value         <= 16'h0000;
      o_dp            <= 4'h0;
      o_valid         <= 1'b0;
      o_error         <= 1'b0;
      o_digitPosition <= 2'd0;
    end else begin
      o_valid <= 1'b0;
      o_error <= 1'b0;
      if (capture_s) begin
        o_digitPosition <= digitPos_s;
      end
      case (state_r)
        ST_IDLE: begin
          timeoutCnt_r <= '0;
          if (capture_s && (digitPos_s == 2'd0)) begin
            state_r            <= ST_COLLECT;
            expected_r         <= 2'd1;
            shadowValue_r[3:0] <= nibble_s;
            shadowDp_r[0]      <= dp_s;
            badFrame_r         <= glyphBad_s;
          end
        end
        ST_COLLECT: begin
          if (capture_s) begin
            timeoutCnt_r <= '0;
            if (digitPos_s == 2'd0) begin
              expected_r         <= 2'd1;
              shadowValue_r[3:0] <= nibble_s;
              shadowDp_r[0]      <= dp_s;
              badFrame_r         <= glyphBad_s;
            end else if (digitPos_s == expected_r) begin
              shadowValue_r[{digitPos_s, 2'b00} +: 4] <= nibble_s;
              shadowDp_r[digitPos_s]                  <= dp_s;
              badFrame_r                              <= badFrame_r | glyphBad_s;
              if (digitPos_s == 2'd3) begin
                state_r <= ST_IDLE;
                if (badFrame_r || glyphBad_s) begin
                  o_error <= 1'b1;
                end else begin
                  o_valid <= 1'b1;
                  o_value <= {nibble_s, shadowValue_r[11:0]};
                  o_dp    <= {dp_s, shadowDp_r[2:0]};
                end
              end else begin
                expected_r <= expected_r + 2'd1;
              end
            end else begin
              o_error <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else if (timeoutCnt_r == TIMEOUT_LAST) begin
            o_error      <= 1'b1;
            state_r      <= ST_IDLE;
            timeoutCnt_r <= '0;
          end else begin
            timeoutCnt_r <= timeoutCnt_r + TIMEOUT_ONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fnd_scan_reader.sv
// Randomized scan stimulus checked against a frame-level reference model of the reader.
module tb_fnd_scan_reader;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 50;
  localparam int LONG    = 10;
  localparam int SHORT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel;
  logic [7:0]  font;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        valid;
  logic        err;
  logic [1:0]  digitPos;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int validCount = 0;
  int errCount = 0;
  int lastErrCycle = -1;
  int lastDriveCycle = 0;

  // reference model state
  int          mState = 0;
  int          mExp = 0;
  logic [3:0]  mNib [4];
  logic        mDp [4];
  logic        mBad = 1'b0;
  int          expValid = 0;
  int          expErr = 0;
  logic [15:0] expValue = 16'h0000;
  logic [3:0]  expDp = 4'h0;
  logic [1:0]  expPos = 2'd0;

  logic [6:0] segTab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                              7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  fnd_scan_reader #(.P_SETTLE_CYCLES(SETTLE), .P_TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst), .i_digitSelect(sel), .i_fndFont(font),
    .o_value(value), .o_dp(dp), .o_valid(valid), .o_error(err), .o_digitPosition(digitPos)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) validCount++;
      if (err) begin
        errCount++;
        lastErrCycle = cycleCount;
      end
      if (valid || err) begin
        checks++;
        if (valid && err) begin
          errors++;
          $display("FAIL exclusive_pulses: valid=%0b error=%0b both high at cycle %0d", valid, err, cycleCount);
        end
      end
    end
  end

  task automatic start_frame(input logic [3:0] nib, input logic d, input logic bad);
    mState = 1; mExp = 1; mNib[0] = nib; mDp[0] = d; mBad = bad;
  endtask

  // frame rules applied to one settled digit
  task automatic model_capture(input int pos, input logic [3:0] nib, input logic d, input logic bad);
    expPos = 2'(pos);
    if (mState == 0) begin
      if (pos == 0) start_frame(nib, d, bad);
    end else if (pos == 0) begin
      start_frame(nib, d, bad);
    end else if (pos == mExp) begin
      mNib[pos] = nib; mDp[pos] = d; mBad = mBad | bad;
      if (pos == 3) begin
        mState = 0;
        if (mBad) expErr++;
        else begin
          expValid++;
          expValue = {mNib[3], mNib[2], mNib[1], mNib[0]};
          expDp = {mDp[3], mDp[2], mDp[1], mDp[0]};
        end
      end else mExp++;
    end else begin
      expErr++;
      mState = 0;
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic [7:0] f, input int cycles);
    lastDriveCycle = cycleCount;
    sel = s; font = f;
    repeat (cycles) @(negedge clk);
  endtask

  // digit 10 means an unrecognised glyph
  task automatic scan_digit(input int pos, input int digit, input logic d, input int dwell);
    logic [6:0] seg;
    logic [3:0] oneHot;
    seg = (digit > 9) ? 7'h7F : segTab[digit];
    oneHot = 4'b0001 << pos;
    drive(~oneHot, {~d, seg}, dwell);
    if (dwell >= SETTLE + 2) model_capture(pos, (digit > 9) ? 4'hF : 4'(digit), d, digit > 9);
  endtask

  task automatic test_reset();
    checks++;
    if ({value, dp, valid, err, digitPos} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", {value, dp, valid, err, digitPos});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({value, dp, valid, err, digitPos} !== 25'd0 || validCount !== 0 || errCount !== 0) begin
      errors++;
      $display("FAIL reset_idle: outputs %h valid=%0d err=%0d, want all 0", {value, dp, valid, err, digitPos}, validCount, errCount);
    end
  endtask

  task automatic test_basic_frame();
    scan_digit(0, 1, 1'b0, LONG);
    scan_digit(1, 2, 1'b0, LONG);
    scan_digit(2, 3, 1'b0, LONG);
    scan_digit(3, 4, 1'b0, LONG);
    checks++;
    if (value !== 16'h4321 || dp !== 4'h0 || validCount !== 1 || errCount !== 0) begin
      errors++;
      $display("FAIL basic_frame: value=%h dp=%b valid=%0d err=%0d, want 4321 0000 1 0", value, dp, validCount, errCount);
    end
    checks++;
    if (digitPos !== 2'd3) begin
      errors++;
      $display("FAIL basic_position: got %0d want 3", digitPos);
    end
  endtask

  task automatic test_short_dwell();
    scan_digit(0, 5, 1'b0, LONG);
    scan_digit(1, 6, 1'b0, SHORT);
    checks++;
    if (digitPos !== 2'd0) begin
      errors++;
      $display("FAIL short_dwell_position: got %0d want 0", digitPos);
    end
    scan_digit(1, 7, 1'b0, LONG);
    scan_digit(2, 8, 1'b1, LONG);
    scan_digit(3, 9, 1'b0, LONG);
    checks++;
    if (value !== 16'h9875 || dp !== 4'b0100 || validCount !== expValid || errCount !== expErr) begin
      errors++;
      $display("FAIL short_dwell_frame: value=%h dp=%b valid=%0d err=%0d, want 9875 0100 %0d %0d",
               value, dp, validCount, errCount, expValid, expErr);
    end
  endtask

  task automatic test_sequence_error();
    int errBefore = errCount;
    int validBefore = validCount;
    logic [15:0] prevValue = value;
    scan_digit(0, 1, 1'b0, LONG);
    scan_digit(1, 1, 1'b0, LONG);
    scan_digit(3, 1, 1'b0, LONG);
    checks++;
    if (errCount !== errBefore + 1 || validCount !== validBefore || value !== prevValue) begin
      errors++;
      $display("FAIL sequence_error: err=%0d valid=%0d value=%h, want %0d %0d %h",
               errCount, validCount, value, errBefore + 1, validBefore, prevValue);
    end
  endtask

  task automatic test_bad_glyph();
    int errBefore = errCount;
    int validBefore = validCount;
    logic [15:0] prevValue = value;
    scan_digit(0, 2, 1'b0, LONG);
    scan_digit(1, 3, 1'b0, LONG);
    scan_digit(2, 10, 1'b0, LONG);
    checks++;
    if (errCount !== errBefore) begin
      errors++;
      $display("FAIL bad_glyph_early: err=%0d, want %0d before position 3", errCount, errBefore);
    end
    scan_digit(3, 4, 1'b0, LONG);
    checks++;
    if (errCount !== errBefore + 1 || validCount !== validBefore || value !== prevValue) begin
      errors++;
      $display("FAIL bad_glyph: err=%0d valid=%0d value=%h, want %0d %0d %h",
               errCount, validCount, value, errBefore + 1, validBefore, prevValue);
    end
  endtask

  task automatic test_timeout();
    int errBefore = errCount;
    int wantCycle;
    scan_digit(0, 3, 1'b0, LONG);
    scan_digit(1, 3, 1'b1, LONG);
    wantCycle = lastDriveCycle + SETTLE + 3 + TIMEOUT;
    drive(4'b1111, 8'hFF, TIMEOUT + 10);
    mState = 0;
    expErr++;
    checks++;
    if (errCount !== errBefore + 1 || lastErrCycle !== wantCycle) begin
      errors++;
      $display("FAIL timeout: err=%0d at cycle %0d, want %0d at cycle %0d", errCount, lastErrCycle, errBefore + 1, wantCycle);
    end
    scan_digit(2, 5, 1'b0, LONG);
    checks++;
    if (errCount !== errBefore + 1) begin
      errors++;
      $display("FAIL timeout_idle: err=%0d, want %0d (position 2 in idle ignored)", errCount, errBefore + 1);
    end
    scan_digit(0, 9, 1'b0, LONG);
    scan_digit(1, 8, 1'b1, LONG);
    scan_digit(2, 7, 1'b0, LONG);
    scan_digit(3, 6, 1'b0, LONG);
    checks++;
    if (value !== 16'h6789 || dp !== 4'b0010 || validCount !== expValid) begin
      errors++;
      $display("FAIL timeout_recovery: value=%h dp=%b valid=%0d, want 6789 0010 %0d", value, dp, validCount, expValid);
    end
  endtask

  task automatic test_reset_midframe();
    scan_digit(0, 4, 1'b0, LONG);
    scan_digit(1, 4, 1'b0, LONG);
    sel = 4'b1111; font = 8'hFF;
    rst = 1'b1;
    #1;
    checks++;
    if ({value, dp, valid, err, digitPos} !== 25'd0) begin
      errors++;
      $display("FAIL reset_midframe: outputs %h, want 0", {value, dp, valid, err, digitPos});
    end
    mState = 0; expValue = 16'h0000; expDp = 4'h0; expPos = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    scan_digit(2, 1, 1'b0, LONG);
    scan_digit(3, 2, 1'b0, LONG);
    scan_digit(0, 0, 1'b1, LONG);
    scan_digit(1, 5, 1'b0, LONG);
    scan_digit(2, 0, 1'b0, LONG);
    scan_digit(3, 7, 1'b1, LONG);
    checks++;
    if (value !== 16'h7050 || dp !== 4'b1001 || validCount !== expValid || errCount !== expErr) begin
      errors++;
      $display("FAIL reset_recovery: value=%h dp=%b valid=%0d err=%0d, want 7050 1001 %0d %0d",
               value, dp, validCount, errCount, expValid, expErr);
    end
  endtask

  task automatic test_random_scans();
    int prevPos = -1;
    bit prevShort = 1'b0;
    drive(4'b1111, 8'hFF, SHORT);
    for (int i = 0; i < 60; i++) begin
      int pos = (prevPos < 0) ? 0 : ($urandom_range(0, 3) != 0 ? (prevPos + 1) % 4 : int'($urandom_range(0, 3)));
      int digit = ($urandom_range(0, 9) == 0) ? 10 : int'($urandom_range(0, 9));
      bit shortDwell = !prevShort && ($urandom_range(0, 6) == 0);
      if (pos == prevPos) pos = (pos + 1) % 4;
      scan_digit(pos, digit, 1'($urandom_range(0, 1)), shortDwell ? SHORT : LONG);
      prevPos = pos;
      prevShort = shortDwell;
      checks++;
      if (validCount !== expValid || errCount !== expErr || value !== expValue || dp !== expDp || digitPos !== expPos) begin
        errors++;
        $display("FAIL random_step%0d: valid=%0d err=%0d value=%h dp=%b pos=%0d, want %0d %0d %h %b %0d",
                 i, validCount, errCount, value, dp, digitPos, expValid, expErr, expValue, expDp, expPos);
      end
    end
    drive(4'b1111, 8'hFF, SHORT);
    for (int p = 0; p < 4; p++) scan_digit(p, int'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), LONG);
    checks++;
    if (validCount !== expValid || errCount !== expErr || value !== expValue || dp !== expDp) begin
      errors++;
      $display("FAIL random_final: valid=%0d err=%0d value=%h dp=%b, want %0d %0d %h %b",
               validCount, errCount, value, dp, expValid, expErr, expValue, expDp);
    end
  endtask

  initial begin
    rst = 1'b1;
    sel = 4'b1111;
    font = 8'hFF;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_frame();
    test_short_dwell();
    test_sequence_error();
    test_bad_glyph();
    test_timeout();
    test_reset_midframe();
    test_random_scans();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fnd_scan_reader.md
FND_SCAN_READER -- requirements
Module: fnd_scan_reader

Interface
REQ-001 SHALL have parameter P_SETTLE_CYCLES, default 4: cycles select+font must stay unchanged before a digit is captured (range 1..255).
REQ-002 SHALL have parameter P_TIMEOUT_CYCLES, default 200000: maximum cycles between captures inside one frame.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: ports i_clk and i_reset.
REQ-004 i_clk  input  1  system clock; all logic on rising edge.
REQ-005 i_reset  input  1  asynchronous active-high reset.
REQ-006 i_digitSelect  input  4  active-low one-cold digit enable from the FND scanner.
REQ-007 i_fndFont  input  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-008 o_value  output  16  last complete frame as 4 BCD nibbles; digit n in bits [4n+3:4n].
REQ-009 o_dp  output  4  decimal-point state per digit (1 = lit) of last complete frame.
REQ-010 o_valid  output  1  one-cycle pulse when o_value/o_dp update.
REQ-011 o_error  output  1  one-cycle pulse on sequence, glyph or timeout error.
REQ-012 o_digitPosition  output  2  position of most recent captured digit.

Function
REQ-013 SHALL register i_digitSelect and i_fndFont once; all decoding uses registered copies (1-cycle input latency).
REQ-014 SHALL encode select 1110->0, 1101->1, 1011->2, 0111->3; any other pattern (blank 1111, multiple lows) is "no digit", never captured, and clears the settle counter.
REQ-015 Settle counter SHALL reset to 0 whenever registered select or font differs from previous cycle, otherwise increment and saturate at P_SETTLE_CYCLES.
REQ-016 SHALL capture exactly once per dwell: the first cycle the counter equals P_SETTLE_CYCLES with a valid digit; no recapture until select/font changes.
REQ-017 SHALL decode font bits g..a: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9; any other pattern stores 4'hF and marks the frame bad; dp = ~i_fndFont[7].
REQ-018 FSM states IDLE, COLLECT: IDLE->COLLECT only on capture at position 0 (frame start, expected = 1); captures at positions 1..3 in IDLE are ignored without error.
REQ-019 In COLLECT, capture at expected position SHALL store nibble/dp in a shadow frame and increment expected; capture at position 0 SHALL restart the frame silently with no error.
REQ-020 In COLLECT, capture at any other position SHALL pulse o_error and go to IDLE.
REQ-021 Capture at position 3 in order SHALL return to IDLE; if no bad glyph, next cycle update o_value/o_dp from shadow and pulse o_valid; else pulse o_error and leave o_value unchanged.
REQ-022 In COLLECT, P_TIMEOUT_CYCLES with no capture SHALL pulse o_error and go to IDLE; timeout counter clears on every capture.
REQ-023 o_valid and o_error SHALL never assert in the same cycle.
REQ-024 o_digitPosition SHALL update on every capture, including in IDLE.

Reset
REQ-025 On i_reset: state IDLE; o_value 16'h0000, o_dp 4'h0, o_valid 0, o_error 0, o_digitPosition 0; all counters, shadow frame and input registers 0 (select register reset to 4'b1111).
REQ-026 Reset mid-frame SHALL discard the partial frame; first frame after release starts at a position-0 capture.

Structure
REQ-027 Shared package fnd_pkg SHALL hold the four select encodings, the ten segment-font constants, and the state enumeration.
REQ-028 SHALL instantiate one sub-module, fnd_font_decoder: combinational 7-bit font -> {bad, 4-bit BCD}.

Verification
REQ-029 Scan 1,2,3,4 on positions 0..3, 10 cycles each -> one o_valid pulse, o_value 16'h4321, o_dp 0, no o_error.
REQ-030 Select dwell of 3 cycles with P_SETTLE_CYCLES=4 -> no capture, o_digitPosition unchanged.
REQ-031 Sequence 0,1,3 -> o_error pulse at position-3 capture, o_value keeps previous value.
REQ-032 Font 7'b1111111 on position 2 of otherwise good frame -> o_error after position 3, no o_valid.
REQ-033 Positions 0,1 then idle P_TIMEOUT_CYCLES (set 50 in bench) -> o_error on cycle 50, state IDLE; following full scan 9,8,7,6 with dp on digit 1 -> o_value 16'h6789, o_dp 4'b0010.
REQ-034 Assert i_reset after positions 0,1 -> all outputs 0 immediately; subsequent full frame captured correctly.
